// File: rtl/led_share_pkg.sv
// Shared constants for the LED sharing controller: pattern modes and FSM states.
package led_share_pkg;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick at TICK_HZ.
module led_tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..TICK_DIV-1 and wrap; never influenced by arbitration.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_share_ctrl.sv
// Arbitrates the active-low LED bank between prioritised status sources,
// running a pattern engine for the owner and a fill-chase heartbeat when idle.
module led_share_ctrl
    import led_share_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 8,
    parameter int NUM_REQ   = 3,
    parameter int LED_W     = 6,
    parameter int MIN_DWELL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_mode,
    input  logic [LED_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     tick,
    output logic [LED_W-1:0]         led
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW_W  = $clog2(MIN_DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MIN_DWELL);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic               phase_q, phase_d;
    logic [1:0]         mode_q, mode_d;
    logic [LED_W-1:0]   data_q, data_d;
    logic [LED_W-1:0]   chase_q, chase_d;
    logic [LED_W-1:0]   idle_q, idle_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic [IDX_W-1:0]   winIdx;
    logic               anyReq;
    logic               ownerReq;
    logic               higherReq;
    logic               dwellFull;
    logic               grantNew;
    logic [LED_W-1:0]   pat;

    led_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .tick_o(tick)
    );

    // Lowest-index active request wins; scanning downward leaves the lowest set bit.
    always_comb begin
        winIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winIdx = IDX_W'(i);
            end
        end
    end

    assign anyReq    = |req;
    assign ownerReq  = |(req & grant_q);
    assign higherReq = |(req & (grant_q - NUM_REQ'(1)));
    assign dwellFull = (dwell_q == DWELL_MAX);

    // Pattern shown while owned, derived from the latched mode and data.
    always_comb begin
        case (mode_q)
            MODE_STATIC: pat = data_q;
            MODE_BLINK:  pat = phase_q ? '0 : data_q;
            MODE_CHASE:  pat = chase_q;
            default:     pat = '0;
        endcase
    end

    // Next-state logic: release beats preemption, and a new grant overrides any tick work.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        dwell_d  = dwell_q;
        phase_d  = phase_q;
        mode_d   = mode_q;
        data_d   = data_q;
        chase_d  = chase_q;
        idle_d   = idle_q;
        grantNew = 1'b0;
        led_d    = ~((state_q == ST_OWNED) ? pat : idle_q);

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    idle_d = idle_q[LED_W-1] ? LED_W'(1) : {idle_q[LED_W-2:0], 1'b1};
                end
                if (anyReq) begin
                    grantNew = 1'b1;
                end
            end
            default: begin
                if (!ownerReq && dwellFull) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (higherReq && dwellFull) begin
                    grantNew = 1'b1;
                end else if (tick) begin
                    if (!dwellFull) begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                    phase_d = ~phase_q;
                    if (mode_q == MODE_CHASE) begin
                        chase_d = {chase_q[LED_W-2:0], chase_q[LED_W-1]};
                    end
                end
            end
        endcase

        if (grantNew) begin
            state_d = ST_OWNED;
            grant_d = NUM_REQ'(1) << winIdx;
            dwell_d = '0;
            phase_d = 1'b0;
            mode_d  = req_mode[2*winIdx +: 2];
            data_d  = req_data[LED_W*winIdx +: LED_W];
            chase_d = req_data[LED_W*winIdx +: LED_W];
        end
    end

    // State and registered outputs; reset blanks the LEDs and drops any grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            dwell_q <= '0;
            phase_q <= 1'b0;
            mode_q  <= MODE_STATIC;
            data_q  <= '0;
            chase_q <= '0;
            idle_q  <= '0;
            led_q   <= '1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            dwell_q <= dwell_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            chase_q <= chase_d;
            idle_q  <= idle_d;
            led_q   <= led_d;
        end
    end

    assign grant = grant_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_share_ctrl.sv
// Self-checking bench for led_share_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_led_share_ctrl;

    localparam int CLK_HZ    = 80;
    localparam int TICK_HZ   = 8;
    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int NUM_REQ   = 3;
    localparam int LED_W     = 6;
    localparam int MIN_DWELL = 2;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [5:0]  reqMode;
    logic [17:0] reqData;
    logic [2:0]  grant;
    logic        tick;
    logic [5:0]  led;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: owner index (-1 idle), ticks seen since grant, idle fill level.
    int         mCnt   = 0;
    int         mOwner = -1;
    int         mTicks = 0;
    int         mFill  = 0;
    int         mMode  = 0;
    int         mData  = 0;
    logic [5:0] mLed   = 6'h3F;

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  mode;
        logic [17:0] data;
        logic [2:0]  expGrant;
        logic [5:0]  expLed;
    } vec_t;

    vec_t tab[6];

    led_share_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .NUM_REQ  (NUM_REQ),
        .LED_W    (LED_W),
        .MIN_DWELL(MIN_DWELL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_mode(reqMode),
        .req_data(reqData),
        .grant   (grant),
        .tick    (tick),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] rotl(input int d, input int r);
        int v;
        v = ((d << r) | (d >> (LED_W - r))) & 63;
        return 6'(v);
    endfunction

    function automatic logic [5:0] modelPat();
        if (mOwner < 0) return 6'((1 << mFill) - 1);
        case (mMode)
            0: return 6'(mData);
            1: return (mTicks % 2 == 1) ? 6'h00 : 6'(mData);
            2: return rotl(mData, mTicks % LED_W);
            default: return 6'h00;
        endcase
    endfunction

    function automatic int lowestReq(input logic [2:0] r);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic takeOwnership(input int w, input logic [5:0] m, input logic [17:0] d);
        mOwner = w;
        mTicks = 0;
        mMode  = int'(m[2*w +: 2]);
        mData  = int'(d[6*w +: 6]);
    endtask

    // Advance the model over one clock edge using the inputs presented before it.
    task automatic modelEdge(input logic r, input logic [2:0] rq, input logic [5:0] m, input logic [17:0] d);
        bit         tickNow;
        bit         full;
        int         w;
        logic [5:0] ledNext;
        if (r) begin
            mCnt = 0; mOwner = -1; mTicks = 0; mFill = 0; mLed = 6'h3F;
            return;
        end
        tickNow = (mCnt == TICK_DIV - 1);
        ledNext = ~modelPat();
        w       = lowestReq(rq);
        mCnt    = (mCnt + 1) % TICK_DIV;
        if (mOwner < 0) begin
            if (tickNow) mFill = (mFill == LED_W) ? 1 : mFill + 1;
            if (w >= 0) takeOwnership(w, m, d);
        end else begin
            full = (mTicks >= MIN_DWELL);
            if (!rq[mOwner] && full) mOwner = -1;
            else if (full && w >= 0 && w < mOwner) takeOwnership(w, m, d);
            else if (tickNow) mTicks++;
        end
        mLed = ledNext;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [5:0] m, input logic [17:0] d);
        req     = r;
        reqMode = m;
        reqData = d;
    endtask

    // One clock: model, edge, then compare every output against the model.
    task automatic step();
        logic [2:0] expGrant;
        modelEdge(rst, req, reqMode, reqData);
        @(posedge clk);
        #1;
        cyc++;
        expGrant = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
        checkOutput("grant", 32'(grant), 32'(expGrant));
        checkOutput("tick", 32'(tick), 32'(mCnt == TICK_DIV - 1));
        checkOutput("led", 32'(led), 32'(mLed));
    endtask

    task automatic stepUntil(input int k);
        while (cyc < k) step();
    endtask

    task automatic doReset();
        applyStimulus(3'b000, 6'h00, 18'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(3'b000, 6'h00, 18'h0);

        tab[0] = '{3'b010, {2'd0, 2'd0, 2'd0}, {6'h00, 6'h2A, 6'h11}, 3'b010, 6'h15};
        tab[1] = '{3'b111, {2'd0, 2'd1, 2'd3}, {6'h3F, 6'h3F, 6'h15}, 3'b001, 6'h3F};
        tab[2] = '{3'b100, {2'd2, 2'd3, 2'd1}, {6'h05, 6'h2A, 6'h3F}, 3'b100, 6'h3A};
        tab[3] = '{3'b110, {2'd0, 2'd1, 2'd2}, {6'h3F, 6'h0F, 6'h01}, 3'b010, 6'h30};
        tab[4] = '{3'b101, {2'd3, 2'd2, 2'd0}, {6'h00, 6'h11, 6'h3F}, 3'b001, 6'h00};
        tab[5] = '{3'b000, {2'd1, 2'd1, 2'd1}, {6'h3F, 6'h3F, 6'h3F}, 3'b000, 6'h3F};

        // Reset state and idle heartbeat.
        doReset();
        checkOutput("rstGrant", 32'(grant), 32'h0);
        checkOutput("rstLed", 32'(led), 32'h3F);
        checkOutput("rstTick", 32'(tick), 32'h0);
        stepUntil(9);  checkOutput("idleTick9", 32'(tick), 32'h1);
        stepUntil(11); checkOutput("idleLed11", 32'(led), 32'h3E);
        stepUntil(21); checkOutput("idleLed21", 32'(led), 32'h3C);
        stepUntil(31); checkOutput("idleLed31", 32'(led), 32'h38);
        stepUntil(39); checkOutput("idleTick39", 32'(tick), 32'h1);

        // Vector table: grant selection, slice latching and first displayed pattern.
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(tab[i].req, tab[i].mode, tab[i].data);
            stepUntil(2);
            checkOutput($sformatf("tab%0dGrant", i), 32'(grant), 32'(tab[i].expGrant));
            checkOutput($sformatf("tab%0dLed", i), 32'(led), 32'(tab[i].expLed));
        end

        // Blink owner preempted only after minimum dwell, with no idle gap.
        doReset();
        applyStimulus(3'b100, {2'd1, 2'd0, 2'd0}, {6'h3F, 6'h00, 6'h00});
        step();
        checkOutput("blinkGrant1", 32'(grant), 32'h4);
        applyStimulus(3'b101, {2'd1, 2'd0, 2'd0}, {6'h3F, 6'h00, 6'h0C});
        stepUntil(5);  checkOutput("blinkLed5", 32'(led), 32'h00);
        stepUntil(11); checkOutput("blinkLed11", 32'(led), 32'h3F);
        stepUntil(20); checkOutput("preemptWait20", 32'(grant), 32'h4);
        step();        checkOutput("preempt21", 32'(grant), 32'h1);

        // Chase owner drops early: held until dwell completes, then idle resumes.
        doReset();
        applyStimulus(3'b010, {2'd0, 2'd2, 2'd0}, {6'h00, 6'h01, 6'h00});
        stepUntil(10);
        applyStimulus(3'b000, {2'd0, 2'd2, 2'd0}, {6'h00, 6'h01, 6'h00});
        stepUntil(11); checkOutput("chaseLed11", 32'(led), 32'h3D);
        stepUntil(20); checkOutput("holdGrant20", 32'(grant), 32'h2);
        step();
        checkOutput("releaseGrant21", 32'(grant), 32'h0);
        checkOutput("releaseLed21", 32'(led), 32'h3B);
        stepUntil(22); checkOutput("idleBack22", 32'(led), 32'h3F);
        stepUntil(31); checkOutput("idleBack31", 32'(led), 32'h3E);

        // Reset while owned.
        doReset();
        applyStimulus(3'b001, 6'h00, {6'h00, 6'h00, 6'h2A});
        stepUntil(4);
        checkOutput("ownedBeforeRst", 32'(grant), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        checkOutput("midRstGrant", 32'(grant), 32'h0);
        checkOutput("midRstLed", 32'(led), 32'h3F);
        checkOutput("midRstTick", 32'(tick), 32'h0);
        stepUntil(9); checkOutput("midRstTick9", 32'(tick), 32'h1);

        // Grant in the tick cycle: that tick does not count toward dwell.
        doReset();
        stepUntil(9);
        checkOutput("coTick9", 32'(tick), 32'h1);
        applyStimulus(3'b001, 6'h00, {6'h00, 6'h00, 6'h07});
        step();
        checkOutput("coGrant10", 32'(grant), 32'h1);
        applyStimulus(3'b000, 6'h00, {6'h00, 6'h00, 6'h07});
        stepUntil(21); checkOutput("coHold21", 32'(grant), 32'h1);
        stepUntil(30); checkOutput("coHold30", 32'(grant), 32'h1);
        step();        checkOutput("coRelease31", 32'(grant), 32'h0);

        // Randomized traffic against the model, with occasional resets.
        doReset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 16 < 3) req = req ^ 3'(1 << ($urandom % 3));
            if ($urandom % 8 == 0) begin
                reqMode = 6'($urandom);
                reqData = 18'($urandom);
            end
            rst = ($urandom % 400 == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
